// File: rtl/popcount_frame_accumulator_if.sv
// Stream interface for the popcount frame accumulator: per-word count beats in,
// per-frame statistics out, each side with its own valid/ready handshake.
interface popcount_frame_accumulator_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 16,
    parameter int WCNT_WIDTH = 16
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    // Count beat stream from the bit counter
    logic [CW-1:0]         count_in;
    logic                  count_valid;
    logic                  count_last;
    logic                  count_ready;

    // Frame result stream towards the reporting logic
    logic [ACC_WIDTH-1:0]  sum_out;
    logic [WCNT_WIDTH-1:0] words_out;
    logic [CW-1:0]         max_out;
    logic                  sat_out;
    logic                  sum_valid;
    logic                  sum_ready;

    modport master (
        output count_in,
        output count_valid,
        output count_last,
        input  count_ready,
        input  sum_out,
        input  words_out,
        input  max_out,
        input  sat_out,
        input  sum_valid,
        output sum_ready
    );

    modport slave (
        input  count_in,
        input  count_valid,
        input  count_last,
        output count_ready,
        output sum_out,
        output words_out,
        output max_out,
        output sat_out,
        output sum_valid,
        input  sum_ready
    );
endinterface

// File: rtl/popcount_frame_accumulator.sv
// Accumulates per-word ones counts over a frame and presents the frame total,
// word count, peak count and a saturation flag on a registered result stream.
module popcount_frame_accumulator #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 16,
    parameter int WCNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    popcount_frame_accumulator_if.slave   bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]         DW_C     = CW'(DATA_WIDTH);
    localparam logic [ACC_WIDTH-1:0]  ACC_MAX  = '1;
    localparam logic [WCNT_WIDTH-1:0] WCNT_MAX = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                state_reg;

    // Running frame accumulators
    logic [ACC_WIDTH-1:0]  acc_reg;
    logic [WCNT_WIDTH-1:0] wcnt_reg;
    logic [CW-1:0]         pmax_reg;
    logic                  sat_reg;

    // Registered frame result
    logic [ACC_WIDTH-1:0]  sum_out_reg;
    logic [WCNT_WIDTH-1:0] words_out_reg;
    logic [CW-1:0]         max_out_reg;
    logic                  sat_out_reg;
    logic                  sum_valid_reg;

    // Next-value candidates for an accepted beat
    logic [CW-1:0]         count_clamped;
    logic [ACC_WIDTH:0]    acc_sum;
    logic                  acc_clip;
    logic                  wcnt_clip;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic [WCNT_WIDTH-1:0] wcnt_next;
    logic [CW-1:0]         pmax_next;
    logic                  sat_next;

    logic                  count_ready_int;
    logic                  accept;
    logic                  accept_last;

    assign count_ready_int = !sum_valid_reg || bus.sum_ready;
    assign accept          = bus.count_valid && count_ready_int;
    assign accept_last     = accept && bus.count_last;

    always_comb begin
        // Counts above DATA_WIDTH cannot come from a legal word; clamp them
        count_clamped = (bus.count_in > DW_C) ? DW_C : bus.count_in;

        // One extra bit on the adder exposes overflow for saturation
        acc_sum   = {1'b0, acc_reg} + (ACC_WIDTH + 1)'(count_clamped);
        acc_clip  = acc_sum[ACC_WIDTH];
        acc_next  = acc_clip ? ACC_MAX : acc_sum[ACC_WIDTH-1:0];

        wcnt_clip = (wcnt_reg == WCNT_MAX);
        wcnt_next = wcnt_clip ? WCNT_MAX : wcnt_reg + 1'b1;

        pmax_next = (count_clamped > pmax_reg) ? count_clamped : pmax_reg;
        sat_next  = sat_reg | acc_clip | wcnt_clip;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= EMPTY;
            acc_reg       <= '0;
            wcnt_reg      <= '0;
            pmax_reg      <= '0;
            sat_reg       <= 1'b0;
            sum_out_reg   <= '0;
            words_out_reg <= '0;
            max_out_reg   <= '0;
            sat_out_reg   <= 1'b0;
            sum_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                if (bus.count_last) begin
                    // Publish the frame including this beat, start the next one empty
                    sum_out_reg   <= acc_next;
                    words_out_reg <= wcnt_next;
                    max_out_reg   <= pmax_next;
                    sat_out_reg   <= sat_next;
                    acc_reg       <= '0;
                    wcnt_reg      <= '0;
                    pmax_reg      <= '0;
                    sat_reg       <= 1'b0;
                end else begin
                    acc_reg       <= acc_next;
                    wcnt_reg      <= wcnt_next;
                    pmax_reg      <= pmax_next;
                    sat_reg       <= sat_next;
                end
            end

            case (state_reg)
                EMPTY: begin
                    if (accept_last) begin
                        state_reg     <= FULL;
                        sum_valid_reg <= 1'b1;
                    end
                end
                FULL: begin
                    // A new last beat in the consume cycle keeps the result stream full
                    if (bus.sum_ready && !accept_last) begin
                        state_reg     <= EMPTY;
                        sum_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= EMPTY;
                    sum_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count_ready = count_ready_int;
    assign bus.sum_out     = sum_out_reg;
    assign bus.words_out   = words_out_reg;
    assign bus.max_out     = max_out_reg;
    assign bus.sat_out     = sat_out_reg;
    assign bus.sum_valid   = sum_valid_reg;

endmodule

// File: tb/tb_popcount_frame_accumulator.sv
// Directed bench for popcount_frame_accumulator: a default-width instance and an
// 8-bit accumulator instance share one stimulus stream.
module tb_popcount_frame_accumulator;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    popcount_frame_accumulator_if #(.DATA_WIDTH(32), .ACC_WIDTH(16), .WCNT_WIDTH(16)) bus ();
    popcount_frame_accumulator_if #(.DATA_WIDTH(32), .ACC_WIDTH(8),  .WCNT_WIDTH(16)) bus8 ();

    assign bus8.count_in    = bus.count_in;
    assign bus8.count_valid = bus.count_valid;
    assign bus8.count_last  = bus.count_last;
    assign bus8.sum_ready   = bus.sum_ready;

    popcount_frame_accumulator #(.DATA_WIDTH(32), .ACC_WIDTH(16), .WCNT_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    popcount_frame_accumulator #(.DATA_WIDTH(32), .ACC_WIDTH(8), .WCNT_WIDTH(16)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive_beat(input logic [5:0] c, input logic last);
        bus.count_in    = c;
        bus.count_valid = 1'b1;
        bus.count_last  = last;
        @(posedge clk);
        #1;
        $display("beat count_in=%0d last=%0d -> sum_valid=%0d sum_out=%0d words_out=%0d max_out=%0d sat_out=%0d",
                 c, last, bus.sum_valid, bus.sum_out, bus.words_out, bus.max_out, bus.sat_out);
    endtask

    task automatic idle_cycle();
        bus.count_valid = 1'b0;
        bus.count_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.sum_valid !== 1'b0) begin errors++; $display("FAIL reset sum_valid got %0d want 0", bus.sum_valid); end
        checks++; if (bus.sum_out !== 16'd0) begin errors++; $display("FAIL reset sum_out got %0d want 0", bus.sum_out); end
        checks++; if (bus.words_out !== 16'd0) begin errors++; $display("FAIL reset words_out got %0d want 0", bus.words_out); end
        checks++; if (bus.max_out !== 6'd0) begin errors++; $display("FAIL reset max_out got %0d want 0", bus.max_out); end
        checks++; if (bus.sat_out !== 1'b0) begin errors++; $display("FAIL reset sat_out got %0d want 0", bus.sat_out); end
        checks++; if (bus.count_ready !== 1'b1) begin errors++; $display("FAIL reset count_ready got %0d want 1", bus.count_ready); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.count_ready !== 1'b1) begin errors++; $display("FAIL reset_release count_ready got %0d want 1", bus.count_ready); end
        $display("reset: sum_valid=%0d count_ready=%0d", bus.sum_valid, bus.count_ready);
    endtask

    task automatic test_four_beat();
        bus.sum_ready = 1'b1;
        drive_beat(6'd0, 1'b0);
        drive_beat(6'd3, 1'b0);
        drive_beat(6'd16, 1'b0);
        checks++; if (bus.sum_valid !== 1'b0) begin errors++; $display("FAIL four_beat early sum_valid got %0d want 0", bus.sum_valid); end
        drive_beat(6'd32, 1'b1);
        checks++; if (bus.sum_valid !== 1'b1) begin errors++; $display("FAIL four_beat sum_valid got %0d want 1", bus.sum_valid); end
        checks++; if (bus.sum_out !== 16'd51) begin errors++; $display("FAIL four_beat sum_out got %0d want 51", bus.sum_out); end
        checks++; if (bus.words_out !== 16'd4) begin errors++; $display("FAIL four_beat words_out got %0d want 4", bus.words_out); end
        checks++; if (bus.max_out !== 6'd32) begin errors++; $display("FAIL four_beat max_out got %0d want 32", bus.max_out); end
        checks++; if (bus.sat_out !== 1'b0) begin errors++; $display("FAIL four_beat sat_out got %0d want 0", bus.sat_out); end
        idle_cycle();
        checks++; if (bus.sum_valid !== 1'b0) begin errors++; $display("FAIL four_beat consumed sum_valid got %0d want 0", bus.sum_valid); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 8; i++) drive_beat(6'd32, (i == 7));
        checks++; if (bus8.sum_out !== 8'd255) begin errors++; $display("FAIL sat8 sum_out got %0d want 255", bus8.sum_out); end
        checks++; if (bus8.sat_out !== 1'b1) begin errors++; $display("FAIL sat8 sat_out got %0d want 1", bus8.sat_out); end
        checks++; if (bus8.words_out !== 16'd8) begin errors++; $display("FAIL sat8 words_out got %0d want 8", bus8.words_out); end
        checks++; if (bus.sum_out !== 16'd256) begin errors++; $display("FAIL sat16 sum_out got %0d want 256", bus.sum_out); end
        checks++; if (bus.sat_out !== 1'b0) begin errors++; $display("FAIL sat16 sat_out got %0d want 0", bus.sat_out); end
        idle_cycle();
        drive_beat(6'd5, 1'b1);
        checks++; if (bus8.sum_out !== 8'd5) begin errors++; $display("FAIL sat8 next sum_out got %0d want 5", bus8.sum_out); end
        checks++; if (bus8.sat_out !== 1'b0) begin errors++; $display("FAIL sat8 next sat_out got %0d want 0", bus8.sat_out); end
        checks++; if (bus8.words_out !== 16'd1) begin errors++; $display("FAIL sat8 next words_out got %0d want 1", bus8.words_out); end
        idle_cycle();
    endtask

    task automatic test_clamp();
        drive_beat(6'd63, 1'b1);
        checks++; if (bus.sum_out !== 16'd32) begin errors++; $display("FAIL clamp sum_out got %0d want 32", bus.sum_out); end
        checks++; if (bus.max_out !== 6'd32) begin errors++; $display("FAIL clamp max_out got %0d want 32", bus.max_out); end
        idle_cycle();
        drive_beat(6'd40, 1'b0);
        drive_beat(6'd1, 1'b1);
        checks++; if (bus.sum_out !== 16'd33) begin errors++; $display("FAIL clamp2 sum_out got %0d want 33", bus.sum_out); end
        checks++; if (bus.words_out !== 16'd2) begin errors++; $display("FAIL clamp2 words_out got %0d want 2", bus.words_out); end
        idle_cycle();
    endtask

    task automatic test_backpressure();
        bus.sum_ready = 1'b0;
        drive_beat(6'd16, 1'b0);
        drive_beat(6'd16, 1'b1);
        checks++; if (bus.sum_out !== 16'd32) begin errors++; $display("FAIL bp sum_out got %0d want 32", bus.sum_out); end
        bus.count_in    = 6'd7;
        bus.count_valid = 1'b1;
        bus.count_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++; if (bus.sum_valid !== 1'b1) begin errors++; $display("FAIL bp hold%0d sum_valid got %0d want 1", i, bus.sum_valid); end
            checks++; if (bus.sum_out !== 16'd32) begin errors++; $display("FAIL bp hold%0d sum_out got %0d want 32", i, bus.sum_out); end
            checks++; if (bus.count_ready !== 1'b0) begin errors++; $display("FAIL bp hold%0d count_ready got %0d want 0", i, bus.count_ready); end
            $display("bp stall %0d: sum_valid=%0d sum_out=%0d count_ready=%0d", i, bus.sum_valid, bus.sum_out, bus.count_ready);
        end
        bus.sum_ready = 1'b1;
        #1;
        checks++; if (bus.count_ready !== 1'b1) begin errors++; $display("FAIL bp release count_ready got %0d want 1", bus.count_ready); end
        @(posedge clk);
        #1;
        checks++; if (bus.sum_valid !== 1'b0) begin errors++; $display("FAIL bp release sum_valid got %0d want 0", bus.sum_valid); end
        drive_beat(6'd1, 1'b1);
        checks++; if (bus.sum_out !== 16'd8) begin errors++; $display("FAIL bp after sum_out got %0d want 8", bus.sum_out); end
        checks++; if (bus.words_out !== 16'd2) begin errors++; $display("FAIL bp after words_out got %0d want 2", bus.words_out); end
        checks++; if (bus.max_out !== 6'd7) begin errors++; $display("FAIL bp after max_out got %0d want 7", bus.max_out); end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic [5:0]  vals [3];
        vals[0] = 6'd3;
        vals[1] = 6'd16;
        vals[2] = 6'd32;
        bus.sum_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_beat(vals[i], 1'b1);
            checks++; if (bus.sum_valid !== 1'b1) begin errors++; $display("FAIL b2b%0d sum_valid got %0d want 1", i, bus.sum_valid); end
            checks++; if (bus.sum_out !== 16'(vals[i])) begin errors++; $display("FAIL b2b%0d sum_out got %0d want %0d", i, bus.sum_out, vals[i]); end
            checks++; if (bus.words_out !== 16'd1) begin errors++; $display("FAIL b2b%0d words_out got %0d want 1", i, bus.words_out); end
        end
        idle_cycle();
        checks++; if (bus.sum_valid !== 1'b0) begin errors++; $display("FAIL b2b end sum_valid got %0d want 0", bus.sum_valid); end
    endtask

    task automatic test_last_ignored();
        bus.count_in    = 6'd9;
        bus.count_valid = 1'b0;
        bus.count_last  = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.sum_valid !== 1'b0) begin errors++; $display("FAIL last_ignored sum_valid got %0d want 0", bus.sum_valid); end
        drive_beat(6'd4, 1'b1);
        checks++; if (bus.sum_out !== 16'd4) begin errors++; $display("FAIL last_ignored sum_out got %0d want 4", bus.sum_out); end
        checks++; if (bus.words_out !== 16'd1) begin errors++; $display("FAIL last_ignored words_out got %0d want 1", bus.words_out); end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        bus.sum_ready = 1'b1;
        drive_beat(6'd9, 1'b1);
        drive_beat(6'd16, 1'b0);
        drive_beat(6'd16, 1'b0);
        bus.count_valid = 1'b0;
        bus.count_last  = 1'b0;
        checks++; if (bus.sum_out !== 16'd9) begin errors++; $display("FAIL rst_mid pre sum_out got %0d want 9", bus.sum_out); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.sum_out !== 16'd0) begin errors++; $display("FAIL rst_mid sum_out got %0d want 0", bus.sum_out); end
        checks++; if (bus.words_out !== 16'd0) begin errors++; $display("FAIL rst_mid words_out got %0d want 0", bus.words_out); end
        checks++; if (bus.max_out !== 6'd0) begin errors++; $display("FAIL rst_mid max_out got %0d want 0", bus.max_out); end
        checks++; if (bus.sum_valid !== 1'b0) begin errors++; $display("FAIL rst_mid sum_valid got %0d want 0", bus.sum_valid); end
        $display("reset mid-frame: sum_out=%0d words_out=%0d", bus.sum_out, bus.words_out);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_beat(6'd3, 1'b1);
        checks++; if (bus.sum_out !== 16'd3) begin errors++; $display("FAIL rst_mid after sum_out got %0d want 3", bus.sum_out); end
        checks++; if (bus.words_out !== 16'd1) begin errors++; $display("FAIL rst_mid after words_out got %0d want 1", bus.words_out); end
        checks++; if (bus.max_out !== 6'd3) begin errors++; $display("FAIL rst_mid after max_out got %0d want 3", bus.max_out); end
        idle_cycle();
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        bus.count_in    = '0;
        bus.count_valid = 1'b0;
        bus.count_last  = 1'b0;
        bus.sum_ready   = 1'b1;

        test_reset();
        test_four_beat();
        test_saturation();
        test_clamp();
        test_backpressure();
        test_back_to_back();
        test_last_ignored();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
